// File: rtl/redmule_z_drain_buffer_if.sv
// redmule_z_drain_buffer_if: Z store stream carrying tile rows from the drain buffer to the streamer.
interface redmule_z_drain_buffer_if #(
  parameter int DW        = 16,
  parameter int ROW_ELEMS = 4
);
  logic                      valid;
  logic                      ready;
  logic                      last;
  logic [ROW_ELEMS*DW-1:0]   data;
  logic [ROW_ELEMS*DW/8-1:0] strb;
  modport master (output valid, data, strb, last, input ready);
  modport slave  (input valid, data, strb, last, output ready);
endinterface

// File: rtl/redmule_z_drain_buffer.sv
// redmule_z_drain_buffer: collects engine rows into a tile, then drains them to the Z stream.
// Optional stall counter on the stream enabled by defining REDMULE_ZBUF_STALL_CNT_EN.
module redmule_z_drain_buffer #(
  parameter int DW        = 16,
  parameter int ROW_ELEMS = 4,
  parameter int DEPTH     = 8,
  localparam int PW = $clog2(DEPTH),
  localparam int RW = $clog2(DEPTH) + 1,
  localparam int CW = $clog2(ROW_ELEMS) + 1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    clear_i,
  input  logic                    clk_en_i,
  input  logic                    z_fill_i,
  input  logic [ROW_ELEMS*DW-1:0] row_i,
  input  logic                    storing_i,
  input  logic [RW-1:0]           cfg_rows_i,
  input  logic [CW-1:0]           cfg_cols_i,
  output logic                    full_o,
  output logic                    empty_o,
  output logic                    overflow_o,
  output logic [31:0]             stall_cnt_o,
  redmule_z_drain_buffer_if.master z
);
  localparam int BPE = DW / 8;
  typedef enum logic [1:0] {FILL, FULL, DRAIN} state_t;
  state_t                  state, state_n;
  logic [ROW_ELEMS*DW-1:0] mem [DEPTH];
  logic [PW-1:0]           wr_ptr, rd_ptr;
  logic [RW-1:0]           cfg_rows, rows_s;
  logic [CW-1:0]           cfg_cols, cols_s;
  logic                    wr_en, hs, last;
  assign wr_en  = z_fill_i && clk_en_i;
  assign hs     = z.valid && z.ready;
  assign last   = {1'b0, rd_ptr} == cfg_rows - RW'(1);
  assign rows_s = (cfg_rows_i == '0 || cfg_rows_i > RW'(DEPTH)) ? RW'(DEPTH) : cfg_rows_i;
  assign cols_s = (cfg_cols_i == '0 || cfg_cols_i > CW'(ROW_ELEMS)) ? CW'(ROW_ELEMS) : cfg_cols_i;
  always_comb begin
    state_n = clear_i ? FILL :
              (state == FILL && wr_en && wr_ptr == PW'(DEPTH - 1)) ? FULL :
              (state == FULL && storing_i) ? DRAIN :
              (state == DRAIN && hs && last) ? FILL : state;
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= FILL;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      cfg_rows   <= RW'(DEPTH);
      cfg_cols   <= CW'(ROW_ELEMS);
      overflow_o <= 1'b0;
    end else if (clear_i) begin
      state      <= FILL;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      cfg_rows   <= RW'(DEPTH);
      cfg_cols   <= CW'(ROW_ELEMS);
      overflow_o <= 1'b0;
    end else begin
      state <= state_n;
      if (state == FILL && wr_en) wr_ptr <= wr_ptr + PW'(1);
      if (hs) rd_ptr <= last ? '0 : rd_ptr + PW'(1);
      if (state == FULL && storing_i) begin
        cfg_rows <= rows_s;
        cfg_cols <= cols_s;
      end
      if (state != FILL && wr_en) overflow_o <= 1'b1;
    end
  end
  // Row storage needs no reset: rows are only read after being written this tile.
  always_ff @(posedge clk_i) begin
    if (state == FILL && wr_en && !clear_i) mem[wr_ptr] <= row_i;
  end
  assign full_o  = state == FULL;
  assign empty_o = state == FILL && wr_ptr == '0;
  assign z.valid = state == DRAIN;
  assign z.data  = mem[rd_ptr];
  assign z.last  = state == DRAIN && last;
  for (genvar i = 0; i < ROW_ELEMS; i++) begin : g_strb
    assign z.strb[i*BPE +: BPE] = (CW'(i) < cfg_cols) ? '1 : '0;
  end
`ifdef REDMULE_ZBUF_STALL_CNT_EN
  logic [31:0] stall_cnt;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) stall_cnt <= '0;
    else if (clear_i) stall_cnt <= '0;
    else if (z.valid && !z.ready && stall_cnt != '1) stall_cnt <= stall_cnt + 32'd1;
  end
  assign stall_cnt_o = stall_cnt;
`else
  assign stall_cnt_o = '0;
`endif
endmodule

// File: tb/tb_redmule_z_drain_buffer.sv
// tb_redmule_z_drain_buffer: directed tile fill/drain scenarios with hand-derived expectations.
module tb_redmule_z_drain_buffer;
  logic        clk = 0, rst = 1, clear = 0, clk_en = 1, z_fill = 0, storing = 0;
  logic [63:0] row = '0;
  logic [3:0]  cfg_rows = '0;
  logic [2:0]  cfg_cols = '0;
  logic        full, empty, overflow;
  logic [31:0] stall_cnt;
  int          total = 0, bad = 0;
  redmule_z_drain_buffer_if #(.DW(16), .ROW_ELEMS(4)) zi ();
  redmule_z_drain_buffer dut (
    .clk_i(clk), .rst_i(rst), .clear_i(clear), .clk_en_i(clk_en), .z_fill_i(z_fill),
    .row_i(row), .storing_i(storing), .cfg_rows_i(cfg_rows), .cfg_cols_i(cfg_cols),
    .full_o(full), .empty_o(empty), .overflow_o(overflow), .stall_cnt_o(stall_cnt), .z(zi.master)
  );
  always #5 clk = ~clk;
  function automatic logic [63:0] rv(input int v);
    logic [15:0] e;
    e = v[15:0];
    return {4{e}};
  endfunction
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic fill_tile(input int base);
    for (int k = 0; k < 8; k++) begin
      z_fill = 1;
      row = rv(base + k);
      tick;
      check("fill_full", full, k == 7);
      check("fill_empty", empty, 0);
    end
    z_fill = 0;
  endtask
  task automatic start_drain;
    storing = 1;
    tick;
    storing = 0;
    check("drain_valid", zi.valid, 1);
    check("drain_full", full, 0);
  endtask
  task automatic drain(input int base, input int n, input logic [7:0] strb);
    zi.ready = 1;
    for (int b = 0; b < n; b++) begin
      check("beat_data", zi.data, rv(base + b));
      check("beat_last", zi.last, b == n - 1);
      check("beat_strb", zi.strb, strb);
      tick;
    end
    zi.ready = 0;
    check("post_valid", zi.valid, 0);
    check("post_empty", empty, 1);
  endtask
  initial begin
    int idx;
    zi.ready = 0;
    tick;
    rst = 0;
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_valid", zi.valid, 0);
    check("rst_last", zi.last, 0);
    check("rst_ovf", overflow, 0);
    check("rst_stall", stall_cnt, 0);
    // full tile, default (zero) cfg treated as whole tile
    fill_tile(0);
    start_drain;
    drain(0, 8, 8'hFF);
    // partial tile: 3 rows, 2 columns
    fill_tile(16);
    cfg_rows = 3;
    cfg_cols = 2;
    start_drain;
    cfg_rows = 0;
    cfg_cols = 0;
    drain(16, 3, 8'h0F);
    // ready pattern 1-0-0-1-...
    fill_tile(32);
    start_drain;
    idx = 0;
    for (int c = 0; c < 20 && idx < 8; c++) begin
      zi.ready = !(c == 1 || c == 2);
      check("stall_data", zi.data, rv(32 + idx));
      check("stall_last", zi.last, idx == 7);
      tick;
      if (zi.ready) idx++;
    end
    zi.ready = 0;
    check("stall_beats", idx, 8);
    check("stall_empty", empty, 1);
`ifdef REDMULE_ZBUF_STALL_CNT_EN
    check("stall_cnt", stall_cnt, 2);
`else
    check("stall_cnt", stall_cnt, 0);
`endif
    // fill while draining
    fill_tile(48);
    start_drain;
    z_fill = 1;
    row = 64'hDEAD_DEAD_DEAD_DEAD;
    tick;
    z_fill = 0;
    check("ovf_set", overflow, 1);
    check("ovf_data", zi.data, rv(48));
    drain(48, 8, 8'hFF);
    check("ovf_sticky", overflow, 1);
    // clear on beat 3
    fill_tile(64);
    start_drain;
    zi.ready = 1;
    for (int b = 0; b < 3; b++) begin
      check("clr_data", zi.data, rv(64 + b));
      tick;
    end
    clear = 1;
    tick;
    clear = 0;
    zi.ready = 0;
    check("clr_valid", zi.valid, 0);
    check("clr_empty", empty, 1);
    check("clr_ovf", overflow, 0);
    check("clr_stall", stall_cnt, 0);
    fill_tile(80);
    start_drain;
    drain(80, 8, 8'hFF);
    // disabled fills are ignored
    clk_en = 0;
    for (int k = 0; k < 4; k++) begin
      z_fill = 1;
      row = rv(200 + k);
      tick;
      check("en_empty", empty, 1);
    end
    z_fill = 0;
    clk_en = 1;
    check("en_ovf", overflow, 0);
    fill_tile(96);
    start_drain;
    drain(96, 8, 8'hFF);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
